uart_tx_scheduler: RTL



---
 rtl/uart_tx_scheduler.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte sources.
// A grant carries at most MAX_BURST bytes, and the frame config changes only while the transmitter is idle.
module uart_tx_scheduler #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4,
  parameter int IDX_W     = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_odd_parity,
  input  logic [N_REQ-1:0]   req_two_stop,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  input  logic               tx_idle,
  output logic               tx_odd_parity,
  output logic               tx_two_stop,
  output logic [IDX_W-1:0]   owner,
  output logic               owner_valid
);

  typedef enum logic [2:0] {IDLE, ARB, DRAIN, LOAD, SEND} state_t;

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  state_t           state, state_next;
  logic [IDX_W-1:0] owner_next, rr_ptr, rr_ptr_next, arb_idx;
  logic             owner_valid_next, tx_valid_next, odd_next, two_next;
  logic             arb_found, do_release, cfg_changed;
  logic [7:0]       tx_data_next;
  logic [3:0]       burst_cnt, burst_next, burst_inc;
  logic [7:0]       req_bytes [N_REQ];
  int               cand;

  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % N_REQ;
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner         <= '0;
      owner_valid   <= 1'b0;
      rr_ptr        <= '0;
      burst_cnt     <= '0;
      tx_valid      <= 1'b0;
      tx_data       <= '0;
      tx_odd_parity <= 1'b0;
      tx_two_stop   <= 1'b0;
    end else begin
      state         <= state_next;
      owner         <= owner_next;
      owner_valid   <= owner_valid_next;
      rr_ptr        <= rr_ptr_next;
      burst_cnt     <= burst_next;
      tx_valid      <= tx_valid_next;
      tx_data       <= tx_data_next;
      tx_odd_parity <= odd_next;
      tx_two_stop   <= two_next;
    end
  end

  always_comb begin
    state_next       = state;
    owner_next       = owner;
    owner_valid_next = owner_valid;
    rr_ptr_next      = rr_ptr;
    burst_next       = burst_cnt;
    tx_valid_next    = tx_valid;
    tx_data_next     = tx_data;
    odd_next         = tx_odd_parity;
    two_next         = tx_two_stop;
    req_ready        = '0;
    do_release       = 1'b0;
    burst_inc        = burst_cnt + 4'd1;
    cfg_changed      = {req_odd_parity[owner], req_two_stop[owner]} != {tx_odd_parity, tx_two_stop};

    case (state)
      IDLE: begin
        if (|req_valid) state_next = ARB;
      end
      ARB: begin
        if (arb_found) begin
          owner_next       = arb_idx;
          owner_valid_next = 1'b1;
          if ({req_odd_parity[arb_idx], req_two_stop[arb_idx]} == {tx_odd_parity, tx_two_stop})
            state_next = LOAD;
          else
            state_next = DRAIN;
        end else begin
          state_next = IDLE;
        end
      end
      DRAIN: begin
        if (tx_idle) begin
          odd_next   = req_odd_parity[owner];
          two_next   = req_two_stop[owner];
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (req_valid[owner]) begin
          req_ready[owner] = 1'b1;
          tx_data_next     = req_bytes[owner];
          tx_valid_next    = 1'b1;
          state_next       = SEND;
        end else begin
          do_release = 1'b1;
        end
      end
      SEND: begin
        if (tx_ready) begin
          tx_valid_next = 1'b0;
          burst_next    = burst_inc;
          if (burst_inc == BURST_LIMIT || !req_valid[owner] || cfg_changed)
            do_release = 1'b1;
          else
            state_next = LOAD;
        end
      end
      default: state_next = IDLE;
    endcase

    // Releasing hands the pointer to the requester after the current owner.
    if (do_release) begin
      rr_ptr_next      = (owner == IDX_W'(N_REQ-1)) ? '0 : owner + 1'b1;
      burst_next       = '0;
      owner_valid_next = 1'b0;
      state_next       = (|req_valid) ? ARB : IDLE;
    end
  end

endmodule
